// File: rtl/nn_pkg.sv
// Shared neuron-datapath definitions: accumulator/activation widths and the
// ReLU + round-half-up + saturate requantizer used by every layer.
package nn_pkg;

    localparam int NN_ACC_W  = 23;
    localparam int NN_DATA_W = 12;

    // Largest positive activation, held at the width of the rounding sum.
    localparam logic [NN_ACC_W:0] NN_ACT_MAX = (NN_ACC_W + 1)'(2 ** (NN_DATA_W - 1) - 1);

    typedef struct packed {
        logic                 sat;
        logic [NN_DATA_W-1:0] data;
    } act_t;

    // The rounding add is done one bit wider than the accumulator, so a value
    // close to full scale cannot wrap negative before the shift.
    function automatic act_t sat_relu(input logic signed [NN_ACC_W-1:0] acc,
                                      input int unsigned shift);
        logic [NN_ACC_W:0] half;
        logic [NN_ACC_W:0] wide;
        act_t              res;
        half = '0;
        wide = '0;
        res  = '0;
        if (!acc[NN_ACC_W-1]) begin
            if (shift > 0) begin
                half = (NN_ACC_W + 1)'(1) << (shift - 1);
            end
            wide = ({1'b0, acc} + half) >> shift;
            if (wide > NN_ACT_MAX) begin
                res.sat  = 1'b1;
                res.data = NN_DATA_W'(NN_ACT_MAX);
            end else begin
                res.data = wide[NN_DATA_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nueron_act_requant_if.sv
// Valid/ready stream bundle; the producer side uses master, the consumer side slave.
interface nueron_act_requant_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, valid, input  ready);
    modport slave  (input  data, valid, output ready);
endinterface

// File: rtl/nn_sync_fifo.sv
// Show-ahead synchronous FIFO: head presents the oldest entry combinationally,
// zero while empty. Pushes to a full FIFO and pops from an empty one are ignored.
module nn_sync_fifo #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty   = (level == '0);
    assign push_en = push && (level != LVL_W'(DEPTH));
    assign pop_en  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; every read is qualified by level,
    // so clearing it would only add reset fan-out and block RAM mapping.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/nueron_act_requant.sv
// Neuron post-accumulator stage: registers the accumulator, applies ReLU and
// requantization, and queues activations in a credit-controlled output FIFO.
module nueron_act_requant
    import nn_pkg::*;
#(
    parameter  int IN_W  = NN_ACC_W,
    parameter  int OUT_W = NN_DATA_W,
    parameter  int SHIFT = 8,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    nueron_act_requant_if.slave   in_bus,
    nueron_act_requant_if.master  out_bus,
    output logic [CNT_W-1:0]      sat_cnt,
    output logic [LVL_W-1:0]      fifo_level
);

    logic signed [IN_W-1:0] s1_data;
    logic                   s1_valid;
    logic                   transfer;
    logic                   fifo_empty;
    logic [LVL_W:0]         credit_used;
    act_t                   act;

    // Credits count both queued entries and the one in flight in stage 1, so
    // in_ready comes from registers only and the FIFO can never be overrun.
    assign credit_used   = {1'b0, fifo_level} + {{LVL_W{1'b0}}, s1_valid};
    assign in_bus.ready  = !rst && (credit_used < (LVL_W + 1)'(DEPTH));
    assign transfer      = in_bus.valid && in_bus.ready;

    assign act = sat_relu(s1_data, SHIFT);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_data <= in_bus.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (s1_valid && act.sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

    nn_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (OUT_W'(act.data)),
        .pop       (out_bus.ready),
        .head      (out_bus.data),
        .level     (fifo_level),
        .empty     (fifo_empty)
    );

    assign out_bus.valid = !fifo_empty;

endmodule
